// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver and its receive buffer so both sides
// agree on word width and state encodings.
package uart_pkg;

    localparam int unsigned SIZE_DEFAULT = 8;

    typedef enum logic {
        W_IDLE    = 1'b0,
        W_CAPTURE = 1'b1
    } wr_state_e;

    typedef enum logic [1:0] {
        idle      = 2'd0,
        starting  = 2'd1,
        receiving = 2'd2
    } rcv_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x SIZE storage with one write port and one registered read port.
// The array itself is not reset; only the read register is.
module sync_fifo_mem #(
    parameter int unsigned SIZE   = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [SIZE-1:0]   wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [SIZE-1:0]   rdata
);

    logic [SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures good bytes, keeps sticky
// error status and back-pressures the receiver before the FIFO can overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned SIZE   = SIZE_DEFAULT,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              sample_clock,
    input  logic              reset,
    input  logic [SIZE-1:0]   rcv_data,
    input  logic              rcv_done,
    input  logic              rcv_error1,
    input  logic              rcv_error2,
    output logic              rcv_not_ready,
    input  logic              rd_en,
    output logic [SIZE-1:0]   rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun_err,
    output logic              frame_err,
    input  logic              clr_err
);

    wr_state_e         state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              capture;
    logic              do_read;
    logic              do_write;
    logic              dropped;
    logic              overrun_set;
    logic              frame_set;
    logic [ADDR_W+1:0] pending;

    always_comb begin
        capture     = (state == W_CAPTURE);
        empty       = (count == '0);
        full        = (count == (ADDR_W+1)'(DEPTH));
        do_read     = rd_en && !empty;
        // A read on the same edge frees a slot, so a capture at full still lands.
        do_write    = capture && (!full || do_read);
        dropped     = capture && !do_write;
        overrun_set = (rcv_done && rcv_error1) || dropped;
        frame_set   = rcv_done && rcv_error2;
        // Count the byte in flight so the receiver is stalled before it is lost.
        pending       = {1'b0, count} + (ADDR_W+2)'(capture);
        rcv_not_ready = (pending >= (ADDR_W+2)'(DEPTH));
    end

    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            state  <= W_IDLE;
            wr_ptr <= '0;
        end else begin
            case (state)
                W_IDLE:    if (rcv_done && !rcv_error1 && !rcv_error2) state <= W_CAPTURE;
                W_CAPTURE: state <= W_IDLE;
                default:   state <= W_IDLE;
            endcase
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            count    <= '0;
        end else begin
            rd_valid <= do_read;
            if (do_read) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_write, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            overrun_err <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (overrun_set)  overrun_err <= 1'b1;
            else if (clr_err) overrun_err <= 1'b0;
            if (frame_set)    frame_err   <= 1'b1;
            else if (clr_err) frame_err   <= 1'b0;
        end
    end

    sync_fifo_mem #(
        .SIZE   (SIZE),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (sample_clock),
        .rst   (reset),
        .we    (do_write),
        .waddr (wr_ptr),
        .wdata (rcv_data),
        .re    (do_read),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver; it shares that receiver's sample_clock domain.
- Captures each good received byte into a DEPTH-entry FIFO.
- Turns the receiver's end-of-frame error flags into sticky status bits.
- Drives the receiver's not-ready input, so the receiver reports overrun (error1) only when the buffer truly has no room.
- Host logic drains bytes through a simple read-enable interface.

Parameters:
SIZE, 8, data word width; must match the receiver's SIZE.
DEPTH, 16, FIFO entries; power of two.
ADDR_W, 4, log2(DEPTH).

Ports:
sample_clock  in  1  single clock, same as the receiver.
reset  in  1  asynchronous, active-high reset.
rcv_data  in  SIZE  receiver's data register output; valid from the edge after rcv_done.
rcv_done  in  1  receiver's read_not_ready_out; one-cycle end-of-frame pulse.
rcv_error1  in  1  receiver overrun flag; meaningful only while rcv_done=1.
rcv_error2  in  1  receiver framing (stop-bit) flag; meaningful only while rcv_done=1.
rcv_not_ready  out  1  drives the receiver's read_not_ready_in.
rd_en  in  1  host read request.
rd_data  out  SIZE  registered read data.
rd_valid  out  1  one-cycle pulse: rd_data holds a new byte.
empty  out  1  FIFO empty.
full  out  1  FIFO full.
count  out  ADDR_W+1  occupancy, 0..DEPTH.
overrun_err  out  1  sticky: receiver overrun seen, or a write was dropped.
frame_err  out  1  sticky: receiver framing error seen.
clr_err  in  1  clears both sticky error bits.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0.
  - rd_data=0, rd_valid=0.
  - overrun_err=0, frame_err=0.
  - write FSM returns to W_IDLE.
  - Reset mid-frame or mid-read discards all contents; memory array contents are don't-care.
- Write FSM, states W_IDLE and W_CAPTURE:
  - W_IDLE -> W_CAPTURE on an edge where rcv_done=1, rcv_error1=0 and rcv_error2=0.
  - W_CAPTURE -> W_IDLE unconditionally after one cycle.
  - In W_CAPTURE: rcv_data (the receiver loaded it on the same edge that rcv_done was sampled) is written to mem[wr_ptr]. wr_ptr increments, wrapping modulo DEPTH.
  - If rcv_done is asserted again while in W_CAPTURE it is still sampled; frames are at least 10 bit-times apart, so this does not occur in legal operation.
- Write latency: the byte is visible in count and empty two edges after the rcv_done edge.
- Flow control:
  - rcv_not_ready = 1 when (count + in_capture) >= DEPTH, where in_capture = 1 while in W_CAPTURE.
  - This is combinational from registers, so no accepted byte is ever lost.
  - The receiver then flags error1 instead of loading.
- Write while full (defensive only): the byte is dropped, pointers are unchanged, and overrun_err is set.
- Error capture:
  - Edge with rcv_done=1 and rcv_error1=1: overrun_err <= 1.
  - Edge with rcv_done=1 and rcv_error2=1: frame_err <= 1.
  - clr_err=1 clears both bits. A simultaneous set wins over clr_err.
- Read:
  - rd_en=1 with empty=0: rd_data <= mem[rd_ptr], rd_ptr increments (wrapping), and rd_valid=1 on the next cycle.
  - rd_en while empty: ignored. rd_valid stays 0 and rd_data holds its value.
- Simultaneous write (W_CAPTURE) and read on the same edge:
  - Both pointers advance and count is unchanged.
  - When full, the read frees the slot first, so the write is accepted.
  - When empty, the read is ignored and the write proceeds; no bypass path.
- Flags: empty=(count==0) and full=(count==DEPTH), derived from the registered count.
- Arithmetic: pointers are ADDR_W bits and wrap naturally. count is ADDR_W+1 bits and never exceeds DEPTH.

Decomposition:
- Shared package uart_pkg holds:
  - the SIZE default;
  - the write-FSM state encodings W_IDLE=1'b0 and W_CAPTURE=1'b1;
  - the receiver state constants idle, starting and receiving, so receiver and buffer agree.
- One sub-module, sync_fifo_mem:
  - DEPTH x SIZE array, one write port and one registered read port;
  - no reset on the array.
- Pointer, count, flag and error logic stays in uart_rx_fifo.

Test Plan:
1. Reset, then one good frame: rcv_done=1 with both errors 0 and rcv_data=8'hA5 the next cycle -> count=1 and empty=0 two edges after the pulse; rd_en -> rd_data=8'hA5 with rd_valid=1 the next cycle, then empty=1.
2. Fill: 16 good frames 8'h00..8'h0F -> full=1, count=16, rcv_not_ready=1. A 17th frame with rcv_error1=1 -> overrun_err=1, count still 16. Drain 16 reads -> data 00..0F in order, with pointer wrap verified.
3. Framing error: rcv_done=1 with rcv_error2=1 -> frame_err=1, count unchanged. clr_err=1 -> frame_err=0. clr_err coincident with a new error2 pulse -> frame_err stays 1.
4. Simultaneous read and write at count=16: W_CAPTURE and rd_en on the same edge -> count stays 16, the oldest byte is output, and the new byte is stored at the wrapped wr_ptr.
5. Read while empty: rd_en=1 for 3 cycles at count=0 -> rd_valid=0, rd_data unchanged, count=0.
6. Asynchronous reset asserted mid-W_CAPTURE at count=5 -> outputs return to reset values immediately without a clock edge; the next good frame after release lands at count=1.
